// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: oversampled I2C target with a pointer-addressed byte register file.
// The first data byte of a write sets the register pointer. Later data bytes write the
// register file and auto-increment the pointer. Reads stream registers starting at the pointer.
module i2c_slave_regfile #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'b1100110,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned PW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_stb,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWrData,
    StWrAck,
    StRdData,
    StRdAck,
    StWaitStop
  } state_e;

  // Synchroniser chains plus one history flop per line
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl_s;
  logic                   sda_s;

  // Bus events derived from synchronised levels only
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  // Protocol state
  state_e          state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [7:0]      rx_byte;
  // Sub-phase flag: in ACK states, set once the ACK is being driven (or the master ACK has
  // been seen); in RD_DATA, set once the eighth bit has been clocked out.
  logic            phase;
  logic            rw;
  logic [PW-1:0]   ptr;
  logic [7:0]      regs [NUM_REGS];

  // Pin synchronisers; reset to the idle-bus level so no false edge follows reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  // Edge and START/STOP decode from the synchronised samples
  always_comb begin
    scl_s     = scl_sync[SYNC_STAGES-1];
    sda_s     = sda_sync[SYNC_STAGES-1];
    scl_rise  = scl_s & ~scl_prev;
    scl_fall  = ~scl_s & scl_prev;
    start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;
    rx_byte   = {shreg[6:0], sda_s};
  end

  // Protocol FSM with registered bus outputs and the register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StIdle;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      phase   <= 1'b0;
      rw      <= 1'b0;
      ptr     <= '0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      wr_stb <= 1'b0;
      if (start_det) begin
        // START or repeated START; the pointer survives
        state   <= StAddr;
        bit_cnt <= 3'd0;
        phase   <= 1'b0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_det) begin
        // STOP discards any partial byte
        state   <= StIdle;
        bit_cnt <= 3'd0;
        phase   <= 1'b0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        unique case (state)
          StAddr: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state <= StAddrAck;
                  rw    <= rx_byte[0];
                end else begin
                  state <= StWaitStop;
                end
              end
            end
          end

          StAddrAck: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_oe <= 1'b1;
                phase  <= 1'b1;
              end else begin
                phase   <= 1'b0;
                bit_cnt <= 3'd0;
                if (rw) begin
                  // First read bit goes out on the fall ending the ACK clock
                  state  <= StRdData;
                  shreg  <= regs[ptr];
                  sda_oe <= ~regs[ptr][7];
                end else begin
                  state  <= StPtr;
                  sda_oe <= 1'b0;
                end
              end
            end
          end

          StPtr: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ptr   <= rx_byte[PW-1:0];
                state <= StPtrAck;
              end
            end
          end

          StPtrAck: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_oe <= 1'b1;
                phase  <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                phase   <= 1'b0;
                bit_cnt <= 3'd0;
                state   <= StWrData;
              end
            end
          end

          StWrData: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= StWrAck;
              end
            end
          end

          StWrAck: begin
            if (scl_fall) begin
              if (!phase) begin
                // Commit the byte together with the ACK drive
                sda_oe     <= 1'b1;
                phase      <= 1'b1;
                wr_stb     <= 1'b1;
                wr_addr    <= ptr;
                wr_data    <= shreg;
                regs[ptr]  <= shreg;
                ptr        <= ptr + 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                phase   <= 1'b0;
                bit_cnt <= 3'd0;
                state   <= StWrData;
              end
            end
          end

          StRdData: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                phase <= 1'b1;
              end
            end else if (scl_fall) begin
              if (phase) begin
                // Byte done: hand SDA to the master for its ACK
                phase  <= 1'b0;
                sda_oe <= 1'b0;
                ptr    <= ptr + 1'b1;
                state  <= StRdAck;
              end else begin
                shreg  <= {shreg[6:0], 1'b0};
                sda_oe <= ~shreg[6];
              end
            end
          end

          StRdAck: begin
            if (scl_rise) begin
              if (sda_s) begin
                state <= StWaitStop;
              end else begin
                phase <= 1'b1;
              end
            end else if (scl_fall && phase) begin
              phase   <= 1'b0;
              bit_cnt <= 3'd0;
              shreg   <= regs[ptr];
              sda_oe  <= ~regs[ptr][7];
              state   <= StRdData;
            end
          end

          default: begin
            // IDLE and WAIT_STOP ignore SCL until the next START or STOP
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

Clock-synchronous, parametrised I2C target with an internal byte register file, successor to the earlier address-only slave. It oversamples SCL/SDA on the system clock, detects START/repeated-START/STOP, matches a configurable 7-bit address, ACKs it, and supports pointer-addressed multi-byte writes and reads with auto-increment. It sits between the board-level open-drain I2C pins and fabric logic, which observes each register write through a strobe.

## Interface

- SLAVE_ADDR, 7'b1100110: 7-bit target address.
- NUM_REGS, 16: register count; power of two, 2..256; PW = clog2(NUM_REGS).
- SYNC_STAGES, 2: input synchroniser depth (≥2).
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- scl_i  in  1  SCL pin level (block never drives SCL).
- sda_i  in  1  SDA pin level.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- busy  out  1  1 from START until STOP.
- wr_stb  out  1  one-cycle pulse per register written.
- wr_addr  out  PW  register index of current wr_stb.
- wr_data  out  8  byte written with wr_stb.

## Operation

- Both inputs pass SYNC_STAGES flops plus one history flop; edges are taken from synchronised values only.
- START: SDA fall while SCL high → state ADDR, bit count 0, busy=1. Valid from any state (repeated START). Pointer retained.
- STOP: SDA rise while SCL high → IDLE, sda_oe=0, busy=0. Valid from any state, including mid-byte; partial byte discarded, no wr_stb.
- START/STOP take priority over an SCL edge detected in the same cycle.
- Bits sampled on SCL rise, MSB first; bit count wraps 0..7.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- ADDR: 8th bit received → if addr[7:1]==SLAVE_ADDR go ADDR_ACK, else WAIT_STOP (no drive).
- ADDR_ACK: R/W=0 → next byte PTR; R/W=1 → RD_DATA.
- PTR byte: pointer ← byte[PW-1:0] (upper bits ignored), ACK, then WR_DATA.
- WR_DATA byte: reg[ptr] ← byte, wr_stb with wr_addr=ptr, ACK, ptr ← ptr+1 mod NUM_REGS; repeats until STOP/START.
- RD_DATA: shift out reg[ptr] (latched at byte start), ptr+1 mod NUM_REGS after byte; RD_ACK samples master bit on SCL rise: 0 → next byte, 1 (NACK) → WAIT_STOP.
- WAIT_STOP: sda_oe=0, ignores SCL until START or STOP.
- Slave always ACKs address match, pointer and data writes; no clock stretching, no general call.

## Timing

- Reset values: sda_oe=0, busy=0, wr_stb=0, wr_addr=0, wr_data=0, ptr=0, all registers 0x00, state IDLE.
- Required SCL high and low phases ≥ SYNC_STAGES+3 clk cycles each.
- sda_oe updates in the cycle after the synchronised SCL fall is detected: ACK asserted at the fall after bit 8, released at the next fall; read bit n driven (sda_oe = ~bit) at the fall preceding its high phase; sda_oe released at the fall ending bit 0 so the master drives ACK.
- wr_stb asserts in the same cycle sda_oe rises for the data-byte ACK; wr_addr/wr_data held until next wr_stb.
- A read immediately following a write within one transfer (via repeated START) returns the post-write pointer's register.
- rst mid-transfer: all outputs to reset values immediately; the block ignores the bus until a new START.

## Test plan

- Write 0xCC, ptr 0x03, data 0xA5, 0x5A, STOP → ACK on all 4 bytes; wr_stb at addr 3 (0xA5) then 4 (0x5A); busy low after STOP.
- Write 0xCC, ptr 0x03, repeated START, 0xCD, read 2 bytes (ACK, NACK) → SDA shows 0xA5, 0x5A; slave releases SDA after 2nd byte.
- Address 0xAA → no ACK (SDA high in 9th clock), no wr_stb, following STOP returns IDLE.
- NUM_REGS=16, ptr 0x1F, write 0x11, 0x22 → writes to regs 15 then 0 (wrap), upper pointer bits ignored.
- STOP after 4 bits of data byte → no wr_stb, register unchanged, busy=0.
- Assert rst while slave drives ACK → sda_oe=0 same cycle, registers cleared, next full write transaction succeeds.
